// File: rtl/control_sequencer.sv
// control_sequencer: single-issue instruction sequencer.
// Captures one instruction per IDLE handshake and decodes it for one EXEC
// cycle. LD/SV then wait in MEM for mem_ack, and LD writes back in the ack
// cycle. Branch/jump inserts FLUSH_CYCLES fetch bubbles. HLT parks in HALTED
// until reset.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   insn_valid/insn/insn_ready - instruction handshake
//   mem_ack/mem_read/mem_write - data-memory request and completion
//   halt..mux_ma, dest, imm, reg_a, reg_b, func_code - decoded controls
//   busy, mem_error (sticky), retired - status
module control_sequencer #(
  parameter int INSN_WIDTH   = 9,
  parameter int DATA_WIDTH   = 8,
  parameter int REG_WIDTH    = 2,
  parameter int FUNC_WIDTH   = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  insn_valid,
  input  logic [INSN_WIDTH-1:0] insn,
  output logic                  insn_ready,
  input  logic                  mem_ack,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  halt,
  output logic                  branch,
  output logic                  jump,
  output logic                  relative,
  output logic                  reg_write,
  output logic                  mux_ri,
  output logic                  overflow_en,
  output logic                  compare_en,
  output logic                  mux_ma,
  output logic [DATA_WIDTH-1:0] dest,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [REG_WIDTH-1:0]  reg_a,
  output logic [REG_WIDTH-1:0]  reg_b,
  output logic [FUNC_WIDTH-1:0] func_code,
  output logic                  busy,
  output logic                  mem_error,
  output logic [CNT_WIDTH-1:0]  retired
);

  localparam int IW = INSN_WIDTH;

  generate
    if (INSN_WIDTH - 2 < 2 * REG_WIDTH + FUNC_WIDTH) begin : g_bad_cfg
      $error("control_sequencer: INSN_WIDTH too small for two register fields plus function code");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_FLUSH, S_HALTED} state_t;

  state_t                r_state, w_next;
  logic [IW-1:0]         r_insn;
  logic [CNT_WIDTH-1:0]  r_retired;
  logic                  r_mem_error;
  logic [3:0]            r_flush_cnt;
  logic [7:0]            r_wait_cnt;

  logic                  w_retire, w_timeout;
  logic [1:0]            w_flag;
  logic [FUNC_WIDTH-1:0] w_fn;
  logic                  w_is_hlt, w_is_ld, w_is_sv, w_is_cmp;

  // Decode works only from the captured instruction, never the live bus.
  assign w_flag   = r_insn[IW-1 -: 2];
  assign w_fn     = r_insn[FUNC_WIDTH-1:0];
  assign w_is_hlt = (w_flag == 2'b11) && (&r_insn);
  assign w_is_ld  = (w_flag == 2'b10) && (w_fn == FUNC_WIDTH'(6));
  assign w_is_sv  = (w_flag == 2'b10) && (w_fn == FUNC_WIDTH'(7));
  assign w_is_cmp = (w_fn == FUNC_WIDTH'(3)) || (w_fn == FUNC_WIDTH'(4)) ||
                    (w_fn == FUNC_WIDTH'(5));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_insn      <= '0;
      r_retired   <= '0;
      r_mem_error <= 1'b0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && insn_valid) r_insn <= insn;
      if (w_retire)  r_retired   <= r_retired + 1'b1;
      if (w_timeout) r_mem_error <= 1'b1;
      // Both counters sit at zero outside their state, so entry starts at 0.
      r_wait_cnt  <= (r_state == S_MEM)   ? r_wait_cnt + 8'd1  : 8'd0;
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 4'd1 : 4'd0;
    end
  end

  // Next state, retirement and timeout.
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: if (insn_valid) w_next = S_EXEC;
      S_EXEC: begin
        if (w_is_ld || w_is_sv) begin
          w_next = S_MEM;
        end else begin
          w_retire = 1'b1;
          if (w_flag == 2'b01) w_next = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
          else if (w_is_hlt)   w_next = S_HALTED;
          else                 w_next = S_IDLE;
        end
      end
      S_MEM: begin
        // An ack in the final allowed cycle still completes normally.
        if (mem_ack) begin
          w_retire = 1'b1;
          w_next   = S_IDLE;
        end else if (r_wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_FLUSH:  if (r_flush_cnt == 4'(FLUSH_CYCLES - 1)) w_next = S_IDLE;
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  // Decoded and handshake outputs; anything not driven by a state stays 0.
  always_comb begin
    insn_ready  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    halt        = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    relative    = 1'b0;
    reg_write   = 1'b0;
    mux_ri      = 1'b0;
    overflow_en = 1'b0;
    compare_en  = 1'b0;
    mux_ma      = 1'b0;
    dest        = '0;
    imm         = '0;
    reg_a       = '0;
    reg_b       = '0;
    func_code   = '0;
    unique case (r_state)
      S_IDLE: insn_ready = 1'b1;
      S_EXEC: begin
        unique case (w_flag)
          2'b00: begin
            reg_a     = r_insn[IW-3 -: REG_WIDTH];
            imm       = DATA_WIDTH'(r_insn[IW-3-REG_WIDTH:0]);
            reg_write = 1'b1;
            mux_ri    = 1'b1;
            mux_ma    = 1'b1;
          end
          2'b01: begin
            branch   = ~r_insn[IW-3];
            jump     = r_insn[IW-3];
            relative = r_insn[IW-4];
            dest     = DATA_WIDTH'(r_insn[IW-5:0]);
          end
          2'b10: begin
            reg_a     = r_insn[IW-3 -: REG_WIDTH];
            reg_b     = r_insn[IW-3-REG_WIDTH -: REG_WIDTH];
            func_code = w_fn;
            if (w_is_cmp) begin
              compare_en = 1'b1;
            end else if (!(w_is_ld || w_is_sv)) begin
              reg_write   = 1'b1;
              overflow_en = 1'b1;
              mux_ma      = 1'b1;
            end
          end
          default: halt = w_is_hlt;
        endcase
      end
      S_MEM: begin
        reg_a     = r_insn[IW-3 -: REG_WIDTH];
        reg_b     = r_insn[IW-3-REG_WIDTH -: REG_WIDTH];
        func_code = w_fn;
        mem_read  = w_is_ld;
        mem_write = w_is_sv;
        // Load write-back selects memory data (mux_ma=0) in the ack cycle.
        reg_write = w_is_ld & mem_ack;
      end
      S_HALTED: halt = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_error = r_mem_error;
  assign retired   = r_retired;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  localparam int FC = 2;
  localparam int MT = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, insn_valid, mem_ack;
  logic [8:0]    insn;
  logic          insn_ready, mem_read, mem_write, halt, branch, jump, relative;
  logic          reg_write, mux_ri, overflow_en, compare_en, mux_ma, busy, mem_error;
  logic [7:0]    dest, imm;
  logic [1:0]    reg_a, reg_b;
  logic [2:0]    func_code;
  logic [CW-1:0] retired;

  control_sequencer #(
    .INSN_WIDTH(9), .DATA_WIDTH(8), .REG_WIDTH(2), .FUNC_WIDTH(3),
    .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .insn_valid(insn_valid), .insn(insn),
    .insn_ready(insn_ready), .mem_ack(mem_ack), .mem_read(mem_read),
    .mem_write(mem_write), .halt(halt), .branch(branch), .jump(jump),
    .relative(relative), .reg_write(reg_write), .mux_ri(mux_ri),
    .overflow_en(overflow_en), .compare_en(compare_en), .mux_ma(mux_ma),
    .dest(dest), .imm(imm), .reg_a(reg_a), .reg_b(reg_b),
    .func_code(func_code), .busy(busy), .mem_error(mem_error), .retired(retired)
  );

  always #5 clk = ~clk;

  // {halt,branch,jump,relative,reg_write,mux_ri,overflow_en,compare_en,mux_ma,dest,imm,reg_a,reg_b,func_code}
  logic [31:0] w_dec;
  assign w_dec = {halt, branch, jump, relative, reg_write, mux_ri, overflow_en,
                  compare_en, mux_ma, dest, imm, reg_a, reg_b, func_code};

  int            nvec = 0;
  int            nmis = 0;
  logic [CW-1:0] exp_ret;

  typedef struct {
    logic [8:0] insn;
    logic [8:0] flags;
    logic [7:0] dest;
    logic [7:0] imm;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [2:0] fn;
    bit         br;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One non-memory instruction: EXEC decode, optional flush bubbles, return to IDLE.
  task automatic run_vec(input vec_t v, input string nm);
    insn = v.insn;
    insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    insn = ~v.insn;  // decode must come from the captured copy
    chk({nm, " dec"}, {32'h0, w_dec}, {32'h0, v.flags, v.dest, v.imm, v.ra, v.rb, v.fn});
    chk({nm, " exec_status"}, {62'h0, busy, insn_ready}, {62'h0, 2'b10});
    exp_ret = exp_ret + 1'b1;
    if (v.br) begin
      for (int k = 0; k < FC; k++) begin
        tick();
        chk({nm, " flush"}, {30'h0, busy, insn_ready, w_dec}, {30'h0, 2'b10, 32'h0});
      end
    end
    tick();
    chk({nm, " done"}, {26'h0, busy, insn_ready, retired, w_dec},
        {26'h0, 2'b01, exp_ret, 32'h0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{9'b00_01_10110,  9'b000011001, 8'h00, 8'h16, 2'd1, 2'd0, 3'd0, 1'b0};
    tbl[1]  = '{9'b00_11_11111,  9'b000011001, 8'h00, 8'h1F, 2'd3, 2'd0, 3'd0, 1'b0};
    tbl[2]  = '{9'b10_01_10_000, 9'b000010101, 8'h00, 8'h00, 2'd1, 2'd2, 3'd0, 1'b0};
    tbl[3]  = '{9'b10_11_00_010, 9'b000010101, 8'h00, 8'h00, 2'd3, 2'd0, 3'd2, 1'b0};
    tbl[4]  = '{9'b10_00_11_011, 9'b000000010, 8'h00, 8'h00, 2'd0, 2'd3, 3'd3, 1'b0};
    tbl[5]  = '{9'b10_10_10_100, 9'b000000010, 8'h00, 8'h00, 2'd2, 2'd2, 3'd4, 1'b0};
    tbl[6]  = '{9'b10_01_01_101, 9'b000000010, 8'h00, 8'h00, 2'd1, 2'd1, 3'd5, 1'b0};
    tbl[7]  = '{9'b11_0000000,   9'b000000000, 8'h00, 8'h00, 2'd0, 2'd0, 3'd0, 1'b0};
    tbl[8]  = '{9'h1FE,          9'b000000000, 8'h00, 8'h00, 2'd0, 2'd0, 3'd0, 1'b0};
    tbl[9]  = '{9'b01_0_0_10011, 9'b010000000, 8'h13, 8'h00, 2'd0, 2'd0, 3'd0, 1'b1};
    tbl[10] = '{9'b01_1_1_00101, 9'b001100000, 8'h05, 8'h00, 2'd0, 2'd0, 3'd0, 1'b1};

    reset = 1'b1; insn_valid = 1'b0; mem_ack = 1'b0; insn = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset", {26'h0, insn_ready, busy, mem_read, mem_write, mem_error, retired, w_dec},
        {26'h0, 5'b10000, 4'h0, 32'h0});
    exp_ret = '0;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Retired counter wrap: fill to 15, then a jump retires to 0.
    while (exp_ret != 4'd15) run_vec(tbl[7], "nop_fill");
    run_vec(tbl[10], "jump_wrap");

    // LD acked in its third MEM cycle.
    insn = 9'b10_10_01_110; insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    chk("ld_exec", {30'h0, mem_read, mem_write, w_dec},
        {30'h0, 2'b00, 9'h0, 16'h0, 2'd2, 2'd1, 3'd6});
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("ld_wait", {30'h0, mem_read, busy, w_dec},
          {30'h0, 2'b11, 9'h0, 16'h0, 2'd2, 2'd1, 3'd6});
    end
    tick();
    mem_ack = 1'b1;
    #1;
    chk("ld_ack", {31'h0, mem_read, w_dec},
        {31'h0, 1'b1, 9'b000010000, 16'h0, 2'd2, 2'd1, 3'd6});
    chk("ld_ack_ret", {60'h0, retired}, {60'h0, exp_ret});
    tick();
    mem_ack = 1'b0;
    exp_ret = exp_ret + 1'b1;
    chk("ld_done", {57'h0, mem_read, insn_ready, busy, retired},
        {57'h0, 3'b010, exp_ret});

    // mem_ack in IDLE is ignored.
    mem_ack = 1'b1;
    tick();
    chk("ack_idle", {56'h0, insn_ready, busy, reg_write, mem_read, retired},
        {56'h0, 4'b1000, exp_ret});
    mem_ack = 1'b0;

    // SV with no ack times out after MT cycles.
    insn = 9'b10_00_01_111; insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    chk("sv_exec", {31'h0, mem_write, w_dec},
        {31'h0, 1'b0, 9'h0, 16'h0, 2'd0, 2'd1, 3'd7});
    for (int k = 0; k < MT; k++) begin
      tick();
      chk("sv_wait", {60'h0, mem_write, mem_read, mem_error, busy}, {60'h0, 4'b1001});
    end
    tick();
    chk("sv_timeout", {56'h0, mem_write, mem_error, insn_ready, busy, retired},
        {56'h0, 4'b0110, exp_ret});

    // Reset in the second MEM cycle of a load.
    insn = 9'b10_10_01_110; insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    tick(); tick();
    chk("rst_mem_pre", {63'h0, mem_read}, {63'h0, 1'b1});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mem", {56'h0, mem_read, busy, insn_ready, mem_error, retired},
        {56'h0, 4'b0010, 4'h0});
    exp_ret = '0;

    // HLT is sticky until reset.
    run_vec(tbl[0], "pre_hlt");
    insn = 9'h1FF; insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    chk("hlt_exec", {32'h0, w_dec}, {32'h0, 9'b100000000, 23'h0});
    exp_ret = exp_ret + 1'b1;
    tick();
    chk("halted", {57'h0, halt, insn_ready, busy, retired}, {57'h0, 3'b101, exp_ret});
    insn = 9'b00_01_10110; insn_valid = 1'b1; mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_hold", {26'h0, w_dec, insn_ready, mem_read, retired},
          {26'h0, 9'b100000000, 23'h0, 2'b00, exp_ret});
    end
    insn_valid = 1'b0; mem_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("hlt_reset", {57'h0, halt, insn_ready, busy, retired}, {57'h0, 3'b010, 4'h0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL take parameters: INSN_WIDTH, default 9, instruction width.
REQ-002 SHALL take parameter DATA_WIDTH, default 8, immediate/destination width.
REQ-003 SHALL take parameter REG_WIDTH, default 2, register-index width.
REQ-004 SHALL take parameter FUNC_WIDTH, default 3, ALU function-code width.
REQ-005 SHALL take parameter FLUSH_CYCLES, default 1, range 0-15, fetch-bubble cycles after any branch/jump.
REQ-006 SHALL take parameter MEM_TIMEOUT, default 15, range 1-255, maximum cycles to wait for mem_ack.
REQ-007 SHALL take parameter CNT_WIDTH, default 16, width of the retired counter.
REQ-008 SHALL have ports: clk input 1 clock; reset input 1 synchronous active-high reset.
REQ-009 SHALL have ports: insn_valid input 1; insn input INSN_WIDTH; insn_ready output 1. Instruction handshake.
REQ-010 SHALL have ports: mem_ack input 1, data-memory completion; mem_read output 1; mem_write output 1.
REQ-011 SHALL have decoded outputs: halt, branch, jump, relative, reg_write, mux_ri, overflow_en, compare_en and mux_ma (each 1 bit); dest and imm (DATA_WIDTH each); reg_a and reg_b (REG_WIDTH each); func_code (FUNC_WIDTH).
REQ-012 SHALL have status outputs: busy output 1; mem_error output 1 (sticky); retired output CNT_WIDTH.
REQ-013 Single clock, reset synchronous active-high; elaboration SHALL fail if INSN_WIDTH-2 < 2*REG_WIDTH+FUNC_WIDTH.

Function
REQ-014 Flag = insn[IW-1:IW-2]: 00 SET, 01 BRANCH/JUMP, 10 OPERATION, 11 HLT if insn is all ones, else NOP.
REQ-015 SET SHALL decode reg_a=insn[IW-3 -: REG_WIDTH], imm=zero-extended insn[IW-3-REG_WIDTH:0], reg_write=mux_ri=mux_ma=1, func_code=0.
REQ-016 BRANCH/JUMP SHALL decode insn[IW-3]=0 to branch=1, =1 to jump=1; relative=insn[IW-4]; dest=zero-extended insn[IW-5:0].
REQ-017 OPERATION SHALL decode reg_a=insn[IW-3 -: REG_WIDTH], reg_b=next REG_WIDTH bits, func_code=insn[FUNC_WIDTH-1:0].
REQ-018 OP codes SHALL be: 3,4,5 compare_en=1; 6 (LD) memory read; 7 (SV) memory write; others reg_write=overflow_en=mux_ma=1.
REQ-019 FSM states SHALL be IDLE, EXEC, MEM, FLUSH, HALTED.
REQ-020 IDLE: insn_ready=1; insn_valid=1 SHALL capture insn into an internal register and go to EXEC next cycle.
REQ-021 Decoded outputs SHALL derive only from the captured register, not live insn.
REQ-022 EXEC SHALL last exactly one cycle and drive decoded outputs.
REQ-023 From EXEC: LD/SV go to MEM; branch/jump go to FLUSH if FLUSH_CYCLES>0, else IDLE; HLT goes to HALTED; others go to IDLE.
REQ-024 MEM SHALL hold reg_a, reg_b, func_code and assert mem_read (LD) or mem_write (SV) until mem_ack or timeout.
REQ-025 LD SHALL assert reg_write with mux_ma=0 only in the cycle mem_ack=1; then IDLE.
REQ-026 A wait counter SHALL clear on MEM entry. If MEM_TIMEOUT cycles pass without mem_ack, it SHALL set mem_error=1, drop the request, skip reg_write, not count retirement, and go to IDLE.
REQ-027 mem_ack outside MEM SHALL be ignored.
REQ-028 FLUSH SHALL last exactly FLUSH_CYCLES cycles, with insn_ready=0 and all decoded outputs 0.
REQ-029 HALTED SHALL hold halt=1 and insn_ready=0, ignoring insn_valid and mem_ack until reset.
REQ-030 retired SHALL increment by 1, wrapping modulo 2^CNT_WIDTH, on the last cycle of each completed instruction, including HLT and NOP.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 In any state, all decoded outputs not listed for that state SHALL be 0.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE, zero the capture register, retired, mem_error, flush and wait counters, and all outputs, except insn_ready=1 the cycle after reset.
REQ-034 Reset SHALL take priority over every transition, including mid-MEM, mid-FLUSH and HALTED; a pending memory request SHALL drop the next cycle.

Verification
REQ-035 SET: insn=9'b00_01_10110 valid in IDLE -> next cycle reg_a=1, imm=8'h16, reg_write=mux_ri=mux_ma=1; retired 0->1.
REQ-036 LD with ack: insn=9'b10_10_01_110, mem_ack after 3 MEM cycles -> mem_read high 3 cycles; reg_write=1, mux_ma=0 only in ack cycle; IDLE next.
REQ-037 Timeout: SV with no ack, MEM_TIMEOUT=4 -> mem_write high 4 cycles; mem_error=1; retired unchanged; IDLE.
REQ-038 Jump, FLUSH_CYCLES=2: insn=9'b01_1_1_00101 -> one cycle jump=1, relative=1, dest=5; insn_ready=0 for 2 cycles; retired wraps 16'hFFFF->0 if preset.
REQ-039 HLT: insn=9'h1FF -> halt=1 sticky, further insn_valid ignored; reset -> IDLE, halt=0, retired=0.
REQ-040 Reset mid-MEM: assert reset during cycle 2 of LD wait -> mem_read=0, busy=0 next cycle; insn_ready=1.
